md_sched: RTL and testbench
===========================

// Module: md_sched
// PURPOSE
//  Sequences the shared multiplier (mul) and iterative divider (div) for the EX stage.
//  Accepts one mult/div/mthi/mtlo op per instruction and drives the unit's operands and start.
//  Raises stallreq until the result exists, then commits it to the architectural HI/LO registers.
//  Sits beside the ALU in EX; its stallreq feeds the pipeline stall controller.
// PARAMETERS
//  MUL_LAT  1  mul pipeline depth: edges from operands presented to mul_result valid (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  flush        in   1   kill the in-flight op (exception/redirect)
//  ex_stall     in   1   a downstream stage holds EX; the instruction stays in EX
//  op_valid     in   1   EX holds a mult/div/mthi/mtlo instruction this cycle
//  op           in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  src_a        in   32  rs operand
//  src_b        in   32  rt operand
//  stallreq     out  1   stall request to the stall controller (combinational)
//  hi_o         out  32  architectural HI (registered)
//  lo_o         out  32  architectural LO (registered)
//  md_done      out  1   one-cycle pulse, registered; the cycle after HI/LO commit
//  mul_signed   out  1   to mul
//  mul_ina      out  32  to mul
//  mul_inb      out  32  to mul
//  mul_result   in   64  from mul, {hi,lo}
//  div_start    out  1   to div; held high until div_ready
//  div_signed   out  1   to div
//  div_opdata1  out  32  to div: dividend
//  div_opdata2  out  32  to div: divisor
//  div_annul    out  1   to div: one-cycle abort
//  div_result   in   64  from div: {remainder, quotient}
//  div_ready    in   1   from div: result valid this cycle
// BEHAVIOUR
//  Reset: state=IDLE, hi_o=lo_o=0, cnt=0, latched operands=0. stallreq, md_done, div_start
//   and div_annul are 0. All unit operand outputs are 0.
//  FSM states: IDLE, MUL_WAIT, DIV_BUSY, HOLD.
//  IDLE, op MULT/MULTU (cycle C0):
//   - mul_ina/inb come from src_a/src_b combinationally.
//   - src_a, src_b and signedness are latched, cnt<=MUL_LAT. stallreq=1. Next state MUL_WAIT.
//  MUL_WAIT:
//   - mul operands come from the latched copies.
//   - While cnt>1: cnt decrements and stallreq=1.
//   - When cnt==1: stallreq=0 and {hi_o,lo_o}<=mul_result at the edge.
//   - Next state is IDLE, or HOLD if ex_stall=1.
//   - EX therefore occupies MUL_LAT+1 cycles.
//  IDLE, op DIV/DIVU (cycle C0):
//   - div_start=1 with operands from src_a/src_b; operands are latched. stallreq=1.
//   - Next state DIV_BUSY.
//  DIV_BUSY:
//   - div_start=1 with the latched operands until div_ready.
//   - In the cycle div_ready=1: div_start=0, stallreq=0, hi_o<=div_result[63:32] (rem),
//     lo_o<=div_result[31:0] (quot).
//   - Next state is IDLE, or HOLD if ex_stall=1.
//  Divide-by-zero: operands are passed through unchanged; HI/LO take whatever div returns.
//  MTHI/MTLO in IDLE: hi_o (or lo_o)<=src_a at the edge; no stall; state stays IDLE.
//   Repeating it under ex_stall is idempotent.
//  HOLD: the finished instruction is still in EX. op_valid is ignored, stallreq=0,
//   HI/LO are not rewritten. Exit to IDLE in the first cycle with ex_stall=0.
//  md_done pulses the cycle after any MUL/DIV commit; it does not pulse for MTHI/MTLO.
//  op_valid in IDLE while ex_stall=1 still accepts; the stall controller ORs the requests.
//  Flush in MUL_WAIT/DIV_BUSY/HOLD:
//   - Next state IDLE; HI/LO unchanged; no md_done.
//   - stallreq=0 that cycle.
//   - div_annul=1 for that one cycle if state is DIV_BUSY (div_start=0).
//   - Flush in IDLE blocks acceptance that cycle.
//  Flush and completion in the same cycle: flush wins, no commit.
//  rst mid-operation: same as reset; div_annul is not needed because div resets too.
//  Invalid op codes (110, 111) are treated as no-op.
// TESTING
//  MULT -3 * 5, MUL_LAT=1 -> stallreq high 1 cycle; hi_o=FFFFFFFF, lo_o=FFFFFFF1; md_done
//   pulses once.
//  MULTU FFFFFFFF*2, MUL_LAT=3 -> stallreq high 3 cycles; hi_o=00000001, lo_o=FFFFFFFE.
//  DIV -7/2, div_ready after 34 cycles -> div_start high through C0..C33;
//   lo_o=FFFFFFFD, hi_o=FFFFFFFF.
//  DIVU 100/7 with ex_stall=1 in the ready cycle for 3 cycles -> one commit (lo=14, hi=2);
//   HOLD 3 cycles; no restart.
//  DIV in flight, flush at cycle 10 -> div_annul 1 cycle; HI/LO unchanged; stallreq=0;
//   next MULT is accepted normally.
//  MTHI 0x12345678, then MTLO 0x9 back-to-back -> hi_o/lo_o updated on successive edges;
//   stallreq never asserted.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer for the EX stage.
// Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per instruction, drives the shared
// multiplier and the iterative divider, stalls EX until the result exists and
// commits it to the architectural HI/LO registers.
//
// Parameters:
//   MUL_LAT      multiplier depth: edges from operands presented to mul_result valid (>=1)
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        kill the in-flight op
//   ex_stall     a downstream stage holds EX
//   op_valid     EX holds a mult/div/mthi/mtlo instruction
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a/src_b  rs/rt operands
//   stallreq     combinational stall request
//   hi_o/lo_o    architectural HI/LO
//   md_done      one-cycle pulse the cycle after a MUL/DIV commit
//   mul_*        multiplier interface (mul_result = {hi,lo})
//   div_*        divider interface (div_result = {remainder, quotient})
module md_sched #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        md_done,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  localparam int unsigned CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          sgn_q;

  logic op_mul;
  logic op_div;
  logic op_mthi;
  logic op_mtlo;
  logic take;

  assign op_mul  = (op == 3'b000) || (op == 3'b001);
  assign op_div  = (op == 3'b010) || (op == 3'b011);
  assign op_mthi = (op == 3'b100);
  assign op_mtlo = (op == 3'b101);
  // A flush in IDLE blocks acceptance for that cycle.
  assign take    = !rst && !flush && op_valid && (state == IDLE);

  // Unit operands come straight from src in the accept cycle, from the latched
  // copies afterwards; everything idles at zero otherwise.
  always_comb begin
    stallreq    = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    div_annul   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (take && op_mul) begin
            stallreq   = 1'b1;
            mul_signed = ~op[0];
            mul_ina    = src_a;
            mul_inb    = src_b;
          end else if (take && op_div) begin
            stallreq    = 1'b1;
            div_start   = 1'b1;
            div_signed  = ~op[0];
            div_opdata1 = src_a;
            div_opdata2 = src_b;
          end
        end
        MUL_WAIT: begin
          mul_signed = sgn_q;
          mul_ina    = a_q;
          mul_inb    = b_q;
          stallreq   = !flush && (cnt > CW'(1));
        end
        DIV_BUSY: begin
          div_signed  = sgn_q;
          div_opdata1 = a_q;
          div_opdata2 = b_q;
          if (flush) begin
            div_annul = 1'b1;
          end else if (!div_ready) begin
            div_start = 1'b1;
            stallreq  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (op_mul || op_div) begin
              a_q   <= src_a;
              b_q   <= src_b;
              sgn_q <= ~op[0];
            end
            if (op_mul) begin
              cnt   <= CW'(MUL_LAT);
              state <= MUL_WAIT;
            end else if (op_div) begin
              state <= DIV_BUSY;
            end else if (op_mthi) begin
              hi_o <= src_a;
            end else if (op_mtlo) begin
              lo_o <= src_a;
            end
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == CW'(1)) begin
            {hi_o, lo_o} <= mul_result;
            md_done      <= 1'b1;
            state        <= ex_stall ? HOLD : IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV_BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_ready) begin
            hi_o    <= div_result[63:32];
            lo_o    <= div_result[31:0];
            md_done <= 1'b1;
            state   <= ex_stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (flush || !ex_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: behavioural multiplier/divider units around the DUT,
// a reference model of architectural HI/LO and a commit scoreboard.
module tb_md_sched;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_stall = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stallreq;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        md_done;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result = '0;
  logic        div_ready = 1'b0;

  md_sched #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .stallreq(stallreq), .hi_o(hi_o), .lo_o(lo_o), .md_done(md_done),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  int div_lat = 2;

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (sgn) return sa * sb;
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {remainder, quotient}; divide-by-zero yields {dividend, all-ones}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiplier: product appears LAT edges after the operands are presented.
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= ref_mul(mul_signed, mul_ina, mul_inb);
    for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[LAT-1];

  // Divider: started by div_start, ready div_lat cycles after the start cycle.
  logic        dbusy = 1'b0;
  int          dcnt = 0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        dsg = 1'b0;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (rst) begin
      dbusy <= 1'b0;
    end else if (dbusy) begin
      if (div_annul) begin
        dbusy <= 1'b0;
      end else if (dcnt <= 1) begin
        div_ready  <= 1'b1;
        div_result <= ref_div(dsg, d1, d2);
        dbusy      <= 1'b0;
      end else begin
        dcnt <= dcnt - 1;
      end
    end else if (div_start) begin
      dbusy <= 1'b1;
      dcnt  <= div_lat - 1;
      d1    <= div_opdata1;
      d2    <= div_opdata2;
      dsg   <= div_signed;
    end
  end

  // Commit monitor.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (md_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL md_done_spurious: got pulse expected none (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("commit_hilo", {hi_o, lo_o}, e);
        end
      end
    end
  end

  // One instruction in EX. fk/rk: cycle index of flush/reset (-1 none);
  // ex_stall is high for cycles sf .. sf+sl-1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int dl, input int fk, input int rk, input int sf, input int sl);
    int ci;
    int killk;
    int stalls;
    int starts;
    int exp_st;
    bit is_mul;
    bit is_div;
    bit retire;
    logic [63:0] r;
    is_mul = (o == 3'd0) || (o == 3'd1);
    is_div = (o == 3'd2) || (o == 3'd3);
    ci = is_mul ? int'(LAT) : (is_div ? dl : 0);
    killk = -1;
    if (fk >= 0 && fk <= ci) killk = fk;
    if (rk >= 0 && rk <= ci && (killk < 0 || rk < killk)) killk = rk;
    div_lat = dl;
    if (killk < 0) begin
      if (is_mul) begin
        r = ref_mul(!o[0], a, b);
        sb_q.push_back(r);
        {arch_hi, arch_lo} = r;
      end else if (is_div) begin
        r = ref_div(!o[0], a, b);
        sb_q.push_back(r);
        {arch_hi, arch_lo} = r;
      end else if (o == 3'd4) begin
        arch_hi = a;
      end else if (o == 3'd5) begin
        arch_lo = a;
      end
    end
    stalls = 0;
    starts = 0;
    for (int j = 0; ; j++) begin
      @(negedge clk);
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      ex_stall = (j >= sf) && (j < sf + sl);
      flush    = (j == fk);
      rst      = (j == rk);
      #1;
      if (stallreq) stalls++;
      if (div_start) starts++;
      chk("div_annul", {63'd0, div_annul}, {63'd0, is_div && flush && !rst && j >= 1 && j <= ci});
      if (flush || rst) chk("stallreq_on_kill", {63'd0, stallreq}, 64'd0);
      retire = flush || rst || (!stallreq && !ex_stall);
      @(posedge clk);
      if (rst) begin
        arch_hi = '0;
        arch_lo = '0;
      end
      if (retire) break;
      if (j >= 300) begin
        vectors++;
        errors++;
        $display("FAIL timeout: op %0d still in EX after %0d cycles expected retire", o, j);
        break;
      end
    end
    #1;
    chk("hi_o", {32'd0, hi_o}, {32'd0, arch_hi});
    chk("lo_o", {32'd0, lo_o}, {32'd0, arch_lo});
    exp_st = (is_mul || is_div) ? ((killk >= 0) ? killk : ci) : 0;
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
    chk("div_start_cycles", 64'(starts), 64'(is_div ? exp_st : 0));
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    int dl;
    int ci;
    int fk;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ctrl", {60'd0, stallreq, md_done, div_start, div_annul}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_mul_ops", {mul_ina, mul_inb}, 64'd0);
    chk("idle_div_ops", {div_opdata1, div_opdata2}, 64'd0);
    chk("idle_ctrl", {60'd0, stallreq, md_done, div_start, div_annul}, 64'd0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 2, -1, -1, 99, 0);         // MULT -3*5
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 2, -1, -1, 99, 0);         // MULTU
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 34, -1, -1, 99, 0);        // DIV -7/2
    issue(3'd3, 32'd100, 32'd7, 10, -1, -1, 10, 3);              // DIVU, HOLD 3
    issue(3'd2, 32'd1234, 32'd5, 34, 10, -1, 99, 0);             // flush at 10
    issue(3'd0, 32'd7, 32'd6, 2, -1, -1, 99, 0);
    issue(3'd4, 32'h1234_5678, 32'd0, 2, -1, -1, 99, 0);         // MTHI
    issue(3'd5, 32'd9, 32'd0, 2, -1, -1, 99, 0);                 // MTLO
    issue(3'd2, 32'd1000, 32'd3, 20, -1, 5, 99, 0);              // reset mid-div
    issue(3'd4, 32'h0000_AAAA, 32'd0, 2, -1, -1, 0, 2);          // MTHI under stall
    issue(3'd6, 32'h1111_1111, 32'd1, 2, -1, -1, 99, 0);
    issue(3'd7, 32'h2222_2222, 32'd1, 2, -1, -1, 0, 1);
    issue(3'd5, 32'd55, 32'd0, 2, 0, -1, 99, 0);                 // flush in IDLE
    issue(3'd0, 32'd3, 32'd4, 2, int'(LAT), -1, 99, 0);          // flush vs commit
    issue(3'd1, 32'd3, 32'd4, 2, int'(LAT) + 2, -1, int'(LAT), 5); // flush in HOLD
    issue(3'd3, 32'd9, 32'd0, 5, -1, -1, 99, 0);                 // divide by zero
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1, -1, 99, 0);

    for (int n = 0; n < 150; n++) begin
      o  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200);
      dl = int'($urandom_range(2, 40));
      ci = (o < 3'd2) ? int'(LAT) : ((o < 3'd4) ? dl : 0);
      fk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ci + 2)) : -1;
      issue(o, a, b, dl, fk, -1, int'($urandom_range(0, 45)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    op_valid = 1'b0;
    flush    = 1'b0;
    ex_stall = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
